// File: rtl/led_pkg.sv
// Shared types for the LED pattern driver: display mode and ping-pong direction.
package led_pkg;

   typedef enum logic [1:0] {
      MODE_GAME,
      MODE_WIN,
      MODE_LOSE
   } led_mode_t;

   typedef enum logic {
      DIR_UP,
      DIR_DOWN
   } led_dir_t;

endpackage

// File: rtl/led_step_tick.sv
// Free-running animation prescaler: counts 0..PERIOD-1 and pulses tick_o on the last count.
// clear_i restarts the count and suppresses a coincident tick.
module led_step_tick #(
   parameter int PERIOD = 6250000
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clear_i,
   output logic tick_o
);

   localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

   logic [CW-1:0] cnt_q;

   assign tick_o = (cnt_q == LAST) && !clear_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else if (clear_i || (cnt_q == LAST)) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + CW'(1);
      end
   end

endmodule

// File: rtl/led_pattern_driver.sv
// Game LED driver: shows the current symbol in game, animates win/lose patterns afterwards,
// and gates every mode with a global PWM brightness.
//
//   state      | meaning
//   MODE_GAME  | leds follow current_symbol_i
//   MODE_WIN   | single LED ping-pongs end to end, one step per tick
//   MODE_LOSE  | all-on/all-off blink 2*LOSE_BLINKS ticks, then hold all-on
module led_pattern_driver
   import led_pkg::*;
#(
   parameter int SYMBOL_W    = 8,
   parameter int LEDS_CNT    = 8,
   parameter int STEP_PERIOD = 6250000,
   parameter int LOSE_BLINKS = 4,
   parameter int PWM_W       = 4
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [SYMBOL_W-1:0] current_symbol_i,
   input  logic                user_in_game_i,
   input  logic                user_win_nlost_i,
   input  logic [PWM_W-1:0]    brightness_i,
   output logic [LEDS_CNT-1:0] leds_o
);

   localparam int BW = $clog2(2 * LOSE_BLINKS + 1);
   localparam logic [BW-1:0] BLINK_END = BW'(2 * LOSE_BLINKS);

   led_mode_t           mode_d, mode_q;
   led_dir_t            dir_d, dir_q;
   logic [LEDS_CNT-1:0] pattern_d, pattern_q;
   logic [LEDS_CNT-1:0] symbol_rs;
   logic [BW-1:0]       blink_d, blink_q;
   logic [PWM_W-1:0]    pwm_cnt_q;
   logic                restart, step_tick, pwm_en;

   generate
      if (SYMBOL_W >= LEDS_CNT) begin : g_sym_trunc
         assign symbol_rs = current_symbol_i[LEDS_CNT-1:0];
      end else begin : g_sym_ext
         assign symbol_rs = {{(LEDS_CNT - SYMBOL_W){1'b0}}, current_symbol_i};
      end
   endgenerate

   always_comb begin
      mode_d = MODE_GAME;
      if (!user_in_game_i) begin
         mode_d = user_win_nlost_i ? MODE_WIN : MODE_LOSE;
      end
   end

   assign restart = (mode_d != mode_q);

   led_step_tick #(
      .PERIOD (STEP_PERIOD)
   ) u_step_tick (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clear_i (restart),
      .tick_o  (step_tick)
   );

   assign pwm_en = (brightness_i == '1) || (pwm_cnt_q < brightness_i);

   always_comb begin
      pattern_d = pattern_q;
      dir_d     = dir_q;
      blink_d   = blink_q;
      if (restart) begin
         dir_d   = DIR_UP;
         blink_d = '0;
         case (mode_d)
            MODE_WIN:  pattern_d = LEDS_CNT'(1);
            MODE_LOSE: pattern_d = '1;
            default:   pattern_d = '0;
         endcase
      end else if (step_tick) begin
         case (mode_q)
            MODE_WIN: begin
               // Direction flips as the lit LED lands on an end, so ends never repeat.
               if (dir_q == DIR_UP) begin
                  pattern_d = pattern_q << 1;
                  if (pattern_q[LEDS_CNT-2]) dir_d = DIR_DOWN;
               end else begin
                  pattern_d = pattern_q >> 1;
                  if (pattern_q[1]) dir_d = DIR_UP;
               end
            end
            MODE_LOSE: begin
               if (blink_q != BLINK_END) begin
                  pattern_d = ~pattern_q;
                  blink_d   = blink_q + BW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         mode_q    <= MODE_GAME;
         dir_q     <= DIR_UP;
         pattern_q <= '0;
         blink_q   <= '0;
         pwm_cnt_q <= '0;
         leds_o    <= '0;
      end else begin
         mode_q    <= mode_d;
         dir_q     <= dir_d;
         pattern_q <= pattern_d;
         blink_q   <= blink_d;
         pwm_cnt_q <= pwm_cnt_q + PWM_W'(1);
         leds_o    <= ((mode_q == MODE_GAME) ? symbol_rs : pattern_q) & {LEDS_CNT{pwm_en}};
      end
   end

endmodule

// File: tb/tb_led_pattern_driver.sv
// Self-checking bench for led_pattern_driver (4 LEDs, 4-cycle steps, 2 lose blinks, 2-bit PWM)
// against a closed-form model of the visible LED sequence.
module tb_led_pattern_driver;

   localparam int N  = 4;
   localparam int SP = 4;
   localparam int LB = 2;
   localparam int PW = 2;
   localparam int G  = 0;
   localparam int W  = 1;
   localparam int L  = 2;

   logic       clk_i;
   logic       rst_i;
   logic [7:0] sym;
   logic       in_game;
   logic       win;
   logic [1:0] bright;
   logic [3:0] leds;

   int         n_checks = 0;
   int         n_fail   = 0;

   int         m_mode;
   int         m_age;
   int         m_pwm;
   logic [3:0] exp_leds;

   led_pattern_driver #(
      .SYMBOL_W    (8),
      .LEDS_CNT    (N),
      .STEP_PERIOD (SP),
      .LOSE_BLINKS (LB),
      .PWM_W       (PW)
   ) dut (
      .clk_i            (clk_i),
      .rst_i            (rst_i),
      .current_symbol_i (sym),
      .user_in_game_i   (in_game),
      .user_win_nlost_i (win),
      .brightness_i     (bright),
      .leds_o           (leds)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // Pattern shown after `age` cycles in a mode: one animation step every SP cycles.
   function automatic logic [3:0] model_pattern(input int mode, input int age);
      logic [3:0] one;
      int k, p, pos;
      one = 4'b0001;
      k = age / SP;
      if (mode == W) begin
         p   = k % (2 * (N - 1));
         pos = (p < N) ? p : 2 * (N - 1) - p;
         return one << pos;
      end
      if (mode == L) begin
         if (k >= 2 * LB) return 4'hF;
         return (k % 2 == 1) ? 4'h0 : 4'hF;
      end
      return 4'h0;
   endfunction

   task automatic model_reset();
      m_mode   = G;
      m_age    = 0;
      m_pwm    = 0;
      exp_leds = 4'h0;
   endtask

   // One clock: predict the registered output from current inputs, then advance the model.
   task automatic cyc();
      logic [3:0] nxt;
      int dec;
      nxt = (m_mode == G) ? sym[3:0] : model_pattern(m_mode, m_age);
      if (!(bright == 2'b11 || m_pwm < int'(bright))) nxt = 4'h0;
      dec = in_game ? G : (win ? W : L);
      @(posedge clk_i);
      #1;
      exp_leds = nxt;
      if (dec != m_mode) begin
         m_mode = dec;
         m_age  = 0;
      end else begin
         m_age++;
      end
      m_pwm = (m_pwm + 1) % (1 << PW);
   endtask

   task automatic test_reset();
      rst_i = 1'b1; in_game = 1'b1; win = 1'b0; bright = 2'b11; sym = 8'h00;
      model_reset();
      #12;
      n_checks++;
      if (leds !== 4'h0) begin n_fail++; $display("FAIL reset_state: leds=%b expected 0000", leds); end
      rst_i = 1'b0;
      in_game = 1'b0; win = 1'b1;
      repeat (9) begin
         cyc();
         n_checks++;
         if (leds !== exp_leds) begin n_fail++; $display("FAIL reset_prewin: leds=%b expected %b", leds, exp_leds); end
      end
      #3 rst_i = 1'b1;
      #1;
      n_checks++;
      if (leds !== 4'h0) begin n_fail++; $display("FAIL reset_async: leds=%b expected 0000", leds); end
      rst_i = 1'b0; in_game = 1'b1; sym = 8'hA5;
      model_reset();
      cyc();
      n_checks++;
      if (leds !== 4'b0101 || leds !== exp_leds) begin
         n_fail++; $display("FAIL reset_symbol: leds=%b expected 0101", leds);
      end
   endtask

   task automatic test_win();
      logic [3:0] seq [8];
      seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
      in_game = 1'b1; bright = 2'b11; sym = 8'($urandom);
      repeat (3) begin
         cyc();
         n_checks++;
         if (leds !== exp_leds) begin n_fail++; $display("FAIL win_game: leds=%b expected %b", leds, exp_leds); end
      end
      in_game = 1'b0; win = 1'b1;
      cyc();
      n_checks++;
      if (leds !== exp_leds) begin n_fail++; $display("FAIL win_latency: leds=%b expected %b", leds, exp_leds); end
      for (int i = 0; i < 8; i++) begin
         if (i > 0) begin
            repeat (3) begin
               cyc();
               n_checks++;
               if (leds !== exp_leds) begin n_fail++; $display("FAIL win_hold: leds=%b expected %b", leds, exp_leds); end
            end
         end
         cyc();
         n_checks++;
         if (leds !== seq[i] || leds !== exp_leds) begin
            n_fail++; $display("FAIL win_seq[%0d]: leds=%b expected %b", i, leds, seq[i]);
         end
      end
   endtask

   task automatic test_lose();
      logic [3:0] seq [5];
      seq = '{4'hF, 4'h0, 4'hF, 4'h0, 4'hF};
      in_game = 1'b1; sym = 8'h06;
      repeat (2) cyc();
      in_game = 1'b0; win = 1'b0;
      cyc();
      n_checks++;
      if (leds !== exp_leds) begin n_fail++; $display("FAIL lose_latency: leds=%b expected %b", leds, exp_leds); end
      for (int i = 0; i < 5; i++) begin
         if (i > 0) begin
            repeat (3) begin
               cyc();
               n_checks++;
               if (leds !== exp_leds) begin n_fail++; $display("FAIL lose_hold: leds=%b expected %b", leds, exp_leds); end
            end
         end
         cyc();
         n_checks++;
         if (leds !== seq[i] || leds !== exp_leds) begin
            n_fail++; $display("FAIL lose_seq[%0d]: leds=%b expected %b", i, leds, seq[i]);
         end
      end
      repeat (44) begin
         cyc();
         n_checks++;
         if (leds !== 4'hF) begin n_fail++; $display("FAIL lose_final: leds=%b expected 1111", leds); end
      end
   endtask

   task automatic test_pwm();
      logic [1:0] b_list [4];
      int         exp_on [4];
      int         on;
      b_list = '{2'd1, 2'd0, 2'd3, 2'd2};
      exp_on = '{2, 0, 8, 4};
      in_game = 1'b1; sym = 8'h0F;
      for (int j = 0; j < 4; j++) begin
         bright = b_list[j];
         cyc();
         on = 0;
         for (int c = 0; c < 8; c++) begin
            cyc();
            n_checks++;
            if (leds !== exp_leds) begin n_fail++; $display("FAIL pwm_cycle: leds=%b expected %b", leds, exp_leds); end
            if (leds === 4'hF) on++;
         end
         n_checks++;
         if (on != exp_on[j]) begin
            n_fail++; $display("FAIL pwm_duty b=%0d: on=%0d expected %0d", b_list[j], on, exp_on[j]);
         end
      end
      bright = 2'b11;
   endtask

   task automatic test_restart_priority();
      int i;
      in_game = 1'b0; win = 1'b1;
      for (i = 0; i < 24 && !(m_mode == W && m_age >= 6 && m_age % SP == SP - 1); i++) begin
         cyc();
         n_checks++;
         if (leds !== exp_leds) begin n_fail++; $display("FAIL prio_pre: leds=%b expected %b", leds, exp_leds); end
      end
      n_checks++;
      if (!(m_mode == W && m_age % SP == SP - 1)) begin
         n_fail++; $display("FAIL prio_align: age=%0d expected terminal count", m_age);
      end
      win = 1'b0;
      cyc();
      for (int c = 2; c <= 6; c++) begin
         cyc();
         n_checks++;
         if (leds !== exp_leds || leds !== ((c == 6) ? 4'h0 : 4'hF)) begin
            n_fail++; $display("FAIL prio_seq c=%0d: leds=%b expected %b", c, leds, (c == 6) ? 4'h0 : 4'hF);
         end
      end
   endtask

   task automatic test_flip();
      in_game = 1'b0;
      for (int i = 0; i < 24; i++) begin
         if (i % 2 == 0) win = ~win;
         cyc();
         n_checks++;
         if (leds !== exp_leds) begin n_fail++; $display("FAIL flip_model: leds=%b expected %b", leds, exp_leds); end
         if (i >= 2) begin
            n_checks++;
            if (leds !== 4'b0001 && leds !== 4'b1111) begin
               n_fail++; $display("FAIL flip_init: leds=%b expected 0001 or 1111", leds);
            end
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(15) == 0) in_game = ~in_game;
         if ($urandom_range(7) == 0) win = 1'($urandom);
         if ($urandom_range(3) == 0) sym = 8'($urandom);
         if ($urandom_range(7) == 0) bright = 2'($urandom);
         cyc();
         n_checks++;
         if (leds !== exp_leds) begin n_fail++; $display("FAIL random[%0d]: leds=%b expected %b", i, leds, exp_leds); end
      end
   endtask

   initial begin
      test_reset();
      test_win();
      test_lose();
      test_pwm();
      test_restart_priority();
      test_flip();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

endmodule
